intr_sched: RTL and testbench
=============================

INTR_SCHED -- requirements
Module: intr_sched

Interface
REQ-001 SHALL have parameter NCH, default 9, number of request channels per priority level.
REQ-002 SHALL have parameter TOUT, default 16, ISSUE-state acknowledge timeout in cycles (2..255).
REQ-003 SHALL have port blif_clk_net, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port blif_reset_net, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port req_a / req_b / req_c, input, NCH each, request lines for levels A (highest), B and C (lowest).
REQ-006 SHALL have port mask_we, input, 1, mask write strobe.
REQ-007 SHALL have port mask_wdata, input, 3*NCH, new mask: bit i = 1 disables that request.
REQ-008 SHALL have port grant_vld, output, 1, grant offered.
REQ-009 SHALL have port grant_lvl, output, 2, level: 0=A, 1=B, 2=C.
REQ-010 SHALL have port grant_ch, output, 4, channel index.
REQ-011 SHALL have port grant_ack, input, 1, grant accepted.
REQ-012 SHALL have port svc_done, input, 1, service of granted request finished.
REQ-013 SHALL have port busy, output, 1, high in ISSUE or SERVICE.
REQ-014 SHALL have port tout_err, output, 1, one-cycle pulse on acknowledge timeout.
REQ-015 SHALL have port pend, output, 3*NCH, pending register.

Function
REQ-016 SHALL set a pend bit on the cycle after a 0->1 transition of its req line, i.e. requests are edge-captured.
REQ-017 SHALL define eligible = pend & ~mask; masked pend bits stay set.
REQ-018 SHALL have FSM states IDLE, ARB, ISSUE, SERVICE.
REQ-019 IDLE->ARB when any eligible bit is set; otherwise stay in IDLE.
REQ-020 ARB SHALL pick the highest non-empty level, then a channel within it (see REQ-031/032), register the winner, and go to ISSUE next cycle.
REQ-021 ISSUE SHALL drive grant_vld=1 with stable grant_lvl/grant_ch.
REQ-022 ISSUE, on grant_ack=1: clear the winner's pend bit and go to SERVICE.
REQ-023 SERVICE, on svc_done=1: go to IDLE; grant_vld=0 throughout SERVICE.
REQ-024 Grant latency: from a set eligible bit in IDLE, grant_vld SHALL rise exactly 2 cycles later.
REQ-025 ISSUE SHALL count cycles without grant_ack; when the count reaches TOUT, pulse tout_err, keep the pend bit, and return to IDLE.
REQ-026 A request edge on the currently granted bit in the same cycle as grant_ack SHALL leave that pend bit set (set wins over clear).
REQ-027 A mask write SHALL take effect the next cycle; masking the winner during ISSUE SHALL NOT revoke the grant.
REQ-028 svc_done or grant_ack outside its own state SHALL be ignored.
REQ-029 grant_lvl/grant_ch SHALL hold the last winner when grant_vld=0.

Reset
REQ-030 On blif_reset_net=0: state=IDLE; pend, mask, edge-detect flops, round-robin pointers, timeout counter = 0; grant_vld=busy=tout_err=0; grant_lvl=grant_ch=0. Asserting reset mid-ISSUE or mid-SERVICE SHALL drop the grant immediately (asynchronously) and discard all pending requests.

Configuration
REQ-031 With INTR_SCHED_RR_EN defined: each level SHALL have a round-robin pointer; the search starts at pointer+1, wrapping from NCH-1 to 0; the pointer updates to the winner on grant_ack.
REQ-032 Without INTR_SCHED_RR_EN: the lowest eligible index in the level SHALL win, and no pointer flops SHALL exist.

Structure
REQ-033 Package intr_sched_pkg SHALL hold the FSM state enum, the level encodings (LVL_A/LVL_B/LVL_C), and the NCH/TOUT defaults.
REQ-034 The per-level channel picker SHALL be one sub-module, intr_pick, instantiated three times (eligible vector plus pointer in, one-hot and index out).

Verification
REQ-035 Single-request handshake: req_b[4] rises; grant_vld=1, grant_lvl=1, grant_ch=4 exactly 2 cycles later; grant_ack then svc_done -> IDLE, pend=0.
REQ-036 Level priority: req_c[0] and req_a[8] rise together -> grant A/8 first; C/0 is granted after svc_done.
REQ-037 Round-robin (macro on): req_a[1], req_a[3], req_a[5] held high and re-pulsed -> grants 1, 3, 5, 1; macro off -> grants 1, 1, 1.
REQ-038 Timeout: grant_ack never asserted with TOUT=16 -> tout_err pulses on the 16th ISSUE cycle; the same request is re-granted 2 cycles later.
REQ-039 Mask: mask bit for A/2 = 1 with req_a[2] and req_b[0] high -> grant B/0; unmasking A/2 -> A/2 granted next.
REQ-040 Reset mid-SERVICE -> grant_vld, busy and pend all 0 while reset is low; after release, no grant without a new req edge.

Source files
------------

// File: rtl/intr_sched_pkg.sv
// Shared types and defaults for the interrupt scheduler.
// Round-robin channel selection is enabled by defining INTR_SCHED_RR_EN.
package intr_sched_pkg;

    localparam int NCH_DEF  = 9;
    localparam int TOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_SERVICE = 2'd3
    } state_e;

    localparam logic [1:0] LVL_A = 2'd0;
    localparam logic [1:0] LVL_B = 2'd1;
    localparam logic [1:0] LVL_C = 2'd2;

endpackage

// File: rtl/intr_sched_pick.sv
// Per-level channel picker: first eligible channel, searching from ptr+1 when
// RR is set, otherwise from index 0.
module intr_pick #(
    parameter int NCH = 9,
    parameter bit RR  = 1'b0
) (
    input  logic [NCH-1:0] elig,
    input  logic [3:0]     ptr,
    output logic [NCH-1:0] onehot,
    output logic [3:0]     idx,
    output logic           any
);

    int unsigned     start;
    int unsigned     cand;
    logic [NCH-1:0]  shifted;
    logic            found;

    always_comb begin
        start   = RR ? 32'(ptr) + 32'd1 : 32'd0;
        if (start >= 32'(NCH)) start = 32'd0;
        onehot  = '0;
        idx     = '0;
        found   = 1'b0;
        cand    = 32'd0;
        shifted = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = start + k;
            if (cand >= 32'(NCH)) cand = cand - 32'(NCH);
            shifted = elig >> cand;
            if (!found && shifted[0]) begin
                found  = 1'b1;
                onehot = {{(NCH-1){1'b0}}, 1'b1} << cand;
                idx    = 4'(cand);
            end
        end
        any = found;
    end

endmodule

// File: rtl/intr_sched.sv
// Three-level edge-captured interrupt scheduler with grant/ack/service handshake.
// Define INTR_SCHED_RR_EN for per-level round-robin; default is lowest-index wins.
module intr_sched
    import intr_sched_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int TOUT = TOUT_DEF
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic [NCH-1:0]   req_a,
    input  logic [NCH-1:0]   req_b,
    input  logic [NCH-1:0]   req_c,
    input  logic             mask_we,
    input  logic [3*NCH-1:0] mask_wdata,
    output logic             grant_vld,
    output logic [1:0]       grant_lvl,
    output logic [3:0]       grant_ch,
    input  logic             grant_ack,
    input  logic             svc_done,
    output logic             busy,
    output logic             tout_err,
    output logic [3*NCH-1:0] pend
);

    localparam int NB = 3 * NCH;
`ifdef INTR_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [NB-1:0]           req_q, req_d;
    logic [NB-1:0]           pend_q, pend_d;
    logic [NB-1:0]           mask_q, mask_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [1:0]              win_lvl_q, win_lvl_d;
    logic [3:0]              win_ch_q, win_ch_d;
    logic [2:0][NCH-1:0]     win_oh_q, win_oh_d;

    logic [NB-1:0]           req_all;
    logic [NB-1:0]           elig;
    logic [NB-1:0]           clr;
    logic [2:0][NCH-1:0]     elig_l;
    logic [2:0][NCH-1:0]     oh_l;
    logic [2:0][3:0]         idx_l;
    logic [2:0][3:0]         ptr_l;
    logic [2:0]              any_l;

    // Level A occupies the low NCH bits of pend/mask, level C the high bits.
    assign req_all = {req_c, req_b, req_a};
    assign elig    = pend_q & ~mask_q;
    assign elig_l  = elig;

    intr_pick #(.NCH(NCH), .RR(RR)) u_pick_a (
        .elig   (elig_l[0]),
        .ptr    (ptr_l[0]),
        .onehot (oh_l[0]),
        .idx    (idx_l[0]),
        .any    (any_l[0])
    );

    intr_pick #(.NCH(NCH), .RR(RR)) u_pick_b (
        .elig   (elig_l[1]),
        .ptr    (ptr_l[1]),
        .onehot (oh_l[1]),
        .idx    (idx_l[1]),
        .any    (any_l[1])
    );

    intr_pick #(.NCH(NCH), .RR(RR)) u_pick_c (
        .elig   (elig_l[2]),
        .ptr    (ptr_l[2]),
        .onehot (oh_l[2]),
        .idx    (idx_l[2]),
        .any    (any_l[2])
    );

`ifdef INTR_SCHED_RR_EN
    logic [2:0][3:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_ISSUE && grant_ack) ptr_d[win_lvl_q] = win_ch_q;
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) ptr_q <= '0;
        else                 ptr_q <= ptr_d;
    end

    assign ptr_l = ptr_q;
`else
    assign ptr_l = '0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_lvl_d = win_lvl_q;
        win_ch_d  = win_ch_q;
        win_oh_d  = win_oh_q;
        tout_err  = 1'b0;
        clr       = '0;
        case (state_q)
            ST_IDLE: begin
                if (|elig) state_d = ST_ARB;
            end
            ST_ARB: begin
                // A mask write landing during IDLE can empty every level here.
                cnt_d    = '0;
                win_oh_d = '0;
                state_d  = ST_ISSUE;
                if (any_l[0]) begin
                    win_lvl_d   = LVL_A;
                    win_ch_d    = idx_l[0];
                    win_oh_d[0] = oh_l[0];
                end else if (any_l[1]) begin
                    win_lvl_d   = LVL_B;
                    win_ch_d    = idx_l[1];
                    win_oh_d[1] = oh_l[1];
                end else if (any_l[2]) begin
                    win_lvl_d   = LVL_C;
                    win_ch_d    = idx_l[2];
                    win_oh_d[2] = oh_l[2];
                end else begin
                    win_oh_d = win_oh_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (grant_ack) begin
                    clr     = win_oh_q;
                    cnt_d   = '0;
                    state_d = ST_SERVICE;
                end else if (cnt_q == 8'(TOUT - 1)) begin
                    tout_err = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SERVICE: begin
                if (svc_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_d  = req_all;
        // A fresh edge on the bit being acknowledged keeps it pending.
        pend_d = (pend_q & ~clr) | (req_all & ~req_q);
        mask_d = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            win_lvl_q <= '0;
            win_ch_q  <= '0;
            win_oh_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            win_lvl_q <= win_lvl_d;
            win_ch_q  <= win_ch_d;
            win_oh_q  <= win_oh_d;
        end
    end

    assign grant_vld = (state_q == ST_ISSUE);
    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_SERVICE);
    assign grant_lvl = win_lvl_q;
    assign grant_ch  = win_ch_q;
    assign pend      = pend_q;

endmodule

// File: tb/tb_intr_sched.sv
// Directed bench for intr_sched with a cycle-level reference model and
// hand-computed expectations for the key scenarios.
module tb_intr_sched;

    localparam int NCH  = 9;
    localparam int TOUT = 16;
    localparam int NB   = 3 * NCH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   req_a = '0, req_b = '0, req_c = '0;
    logic             mask_we = 1'b0;
    logic [NB-1:0]    mask_wdata = '0;
    logic             grant_ack = 1'b0, svc_done = 1'b0;
    logic             grant_vld, busy, tout_err;
    logic [1:0]       grant_lvl;
    logic [3:0]       grant_ch;
    logic [NB-1:0]    pend;

    int tests = 0;
    int fails = 0;

    intr_sched #(.NCH(NCH), .TOUT(TOUT)) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_c          (req_c),
        .mask_we        (mask_we),
        .mask_wdata     (mask_wdata),
        .grant_vld      (grant_vld),
        .grant_lvl      (grant_lvl),
        .grant_ch       (grant_ch),
        .grant_ack      (grant_ack),
        .svc_done       (svc_done),
        .busy           (busy),
        .tout_err       (tout_err),
        .pend           (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 waiting, 1 choosing, 2 offering, 3 servicing.
    bit [NB-1:0] m_pend = '0, m_mask = '0, m_prev = '0;
    int m_phase = 0, m_cnt = 0, m_wl = 0, m_wc = 0;
    int m_ptr[3] = '{0, 0, 0};

    function automatic void mpick(input bit [NB-1:0] e, output bit f, output int l, output int c);
        f = 1'b0; l = 0; c = 0;
        for (int lv = 0; lv < 3; lv++) begin
            int base;
`ifdef INTR_SCHED_RR_EN
            base = (m_ptr[lv] + 1) % NCH;
`else
            base = 0;
`endif
            for (int k = 0; k < NCH; k++) begin
                int ch;
                ch = (base + k) % NCH;
                if (!f && e[lv*NCH+ch]) begin
                    f = 1'b1; l = lv; c = ch;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit [NB-1:0] now, rise, elig;
        bit f;
        int l, c;
        if (!rst_n) begin
            m_pend = '0; m_mask = '0; m_prev = '0;
            m_phase = 0; m_cnt = 0; m_wl = 0; m_wc = 0;
            m_ptr = '{0, 0, 0};
        end else begin
            now    = {req_c, req_b, req_a};
            rise   = now & ~m_prev;
            m_prev = now;
            elig   = m_pend & ~m_mask;
            case (m_phase)
                0: if (elig != 0) m_phase = 1;
                1: begin
                    mpick(elig, f, l, c);
                    if (f) begin m_wl = l; m_wc = c; m_cnt = 0; m_phase = 2; end
                    else m_phase = 0;
                end
                2: if (grant_ack) begin
                    m_pend[m_wl*NCH+m_wc] = 1'b0;
                    m_ptr[m_wl] = m_wc;
                    m_phase = 3;
                end else if (m_cnt == TOUT - 1) m_phase = 0;
                else m_cnt++;
                default: if (svc_done) m_phase = 0;
            endcase
            m_pend |= rise;
            if (mask_we) m_mask = mask_wdata;
        end
    end

    always @(negedge clk) begin
        check("m_grant_vld", grant_vld, m_phase == 2);
        check("m_busy", busy, m_phase >= 2);
        check("m_tout_err", tout_err, m_phase == 2 && m_cnt == TOUT - 1 && !grant_ack);
        check("m_grant_lvl", grant_lvl, m_wl);
        check("m_grant_ch", grant_ch, m_wc);
        check("m_pend", pend, m_pend);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic get_grant(input int maxc, output int l, output int c, output int waited);
        waited = 0;
        while (!grant_vld && waited < maxc) begin
            cyc();
            waited++;
        end
        check("grant_wait", grant_vld, 1);
        l = grant_lvl;
        c = grant_ch;
    endtask

    task automatic ack_done();
        grant_ack = 1'b1; cyc(); grant_ack = 1'b0;
        svc_done  = 1'b1; cyc(); svc_done  = 1'b0;
    endtask

    task automatic drain();
        int l, c, w;
        for (int i = 0; i < 30; i++) begin
            if (pend == '0 && !busy) break;
            get_grant(8, l, c, w);
            ack_done();
        end
        check("drain_pend", pend, 0);
    endtask

    initial begin
        int l, c, w, tk;
        int exp_rr[4];
`ifdef INTR_SCHED_RR_EN
        exp_rr = '{1, 3, 5, 1};
`else
        exp_rr = '{1, 1, 1, 1};
`endif
        repeat (3) cyc();
        check("rst_vld", grant_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_tout", tout_err, 0);
        check("rst_pend", pend, 0);
        check("rst_lvl", grant_lvl, 0);
        check("rst_ch", grant_ch, 0);
        rst_n = 1'b1;
        cyc();

        // Single request handshake on B/4.
        req_b[4] = 1'b1; cyc();
        check("s1_pend_set", pend[NCH+4], 1);
        check("s1_vld_c0", grant_vld, 0);
        cyc();
        check("s1_vld_c1", grant_vld, 0);
        cyc();
        check("s1_vld_c2", grant_vld, 1);
        check("s1_lvl", grant_lvl, 1);
        check("s1_ch", grant_ch, 4);
        grant_ack = 1'b1; req_b[4] = 1'b0; cyc(); grant_ack = 1'b0;
        check("s1_svc_vld", grant_vld, 0);
        check("s1_svc_busy", busy, 1);
        check("s1_pend_clr", pend, 0);
        grant_ack = 1'b1; cyc(); grant_ack = 1'b0;
        check("s1_stray_ack", busy, 1);
        svc_done = 1'b1; cyc(); svc_done = 1'b0;
        check("s1_idle", busy, 0);
        check("s1_hold_ch", grant_ch, 4);
        svc_done = 1'b1; cyc(); svc_done = 1'b0;

        // Acknowledge timeout on C/7.
        req_c[7] = 1'b1; cyc(); req_c[7] = 1'b0;
        cyc(); cyc();
        check("s2_vld", grant_vld, 1);
        tk = 0;
        for (int k = 1; k <= 20; k++) begin
            if (tout_err) begin tk = k; break; end
            cyc();
        end
        check("s2_tout_cycle", tk, 16);
        cyc();
        check("s2_vld_drop", grant_vld, 0);
        check("s2_pend_kept", pend[2*NCH+7], 1);
        cyc();
        check("s2_vld_mid", grant_vld, 0);
        cyc();
        check("s2_regrant", grant_vld, 1);
        check("s2_regrant_ch", grant_ch, 7);
        ack_done();

        // Level priority: A/8 before C/0.
        req_c[0] = 1'b1; req_a[8] = 1'b1; cyc(); req_c[0] = 1'b0; req_a[8] = 1'b0;
        get_grant(6, l, c, w);
        check("s3_first_lvl", l, 0);
        check("s3_first_ch", c, 8);
        check("s3_lat", w, 2);
        ack_done();
        get_grant(6, l, c, w);
        check("s3_second_lvl", l, 2);
        check("s3_second_ch", c, 0);
        check("s3_lat2", w, 2);
        ack_done();

        // Channel selection order within level A.
        req_a[1] = 1'b1; req_a[3] = 1'b1; req_a[5] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            get_grant(8, l, c, w);
            check("s4_lvl", l, 0);
            check("s4_ch", c, exp_rr[g]);
            grant_ack = 1'b1; cyc(); grant_ack = 1'b0;
            if (g < 3) begin
                req_a[1] = 1'b0; req_a[3] = 1'b0; req_a[5] = 1'b0; cyc();
                req_a[1] = 1'b1; req_a[3] = 1'b1; req_a[5] = 1'b1; cyc();
            end
            svc_done = 1'b1; cyc(); svc_done = 1'b0;
        end
        req_a = '0;
        drain();

        // Masking A/2 defers it behind B/0; masking during ISSUE keeps the grant.
        mask_we = 1'b1; mask_wdata = '0; mask_wdata[2] = 1'b1; cyc(); mask_we = 1'b0;
        req_a[2] = 1'b1; req_b[0] = 1'b1; cyc(); req_a[2] = 1'b0; req_b[0] = 1'b0;
        get_grant(6, l, c, w);
        check("s5_lvl", l, 1);
        check("s5_ch", c, 0);
        check("s5_masked_pend", pend[2], 1);
        grant_ack = 1'b1; cyc(); grant_ack = 1'b0;
        svc_done = 1'b1; mask_we = 1'b1; mask_wdata = '0; cyc();
        svc_done = 1'b0; mask_we = 1'b0;
        get_grant(6, l, c, w);
        check("s5_unmask_lvl", l, 0);
        check("s5_unmask_ch", c, 2);
        check("s5_unmask_lat", w, 2);
        mask_we = 1'b1; mask_wdata = '1; cyc(); mask_we = 1'b0;
        check("s5_no_revoke", grant_vld, 1);
        check("s5_no_revoke_ch", grant_ch, 2);
        ack_done();
        mask_we = 1'b1; mask_wdata = '0; cyc(); mask_we = 1'b0;
        drain();

        // New edge on the granted bit in the acknowledge cycle keeps it pending.
        req_b[6] = 1'b1; cyc(); req_b[6] = 1'b0;
        get_grant(6, l, c, w);
        check("s6_ch", c, 6);
        grant_ack = 1'b1; req_b[6] = 1'b1; cyc(); grant_ack = 1'b0; req_b[6] = 1'b0;
        check("s6_set_wins", pend[NCH+6], 1);
        svc_done = 1'b1; cyc(); svc_done = 1'b0;
        get_grant(6, l, c, w);
        check("s6_regrant_lvl", l, 1);
        check("s6_regrant_ch", c, 6);
        ack_done();
        check("s6_pend_empty", pend, 0);

        // Reset while servicing.
        req_a[0] = 1'b1; cyc(); req_a[0] = 1'b0;
        get_grant(6, l, c, w);
        grant_ack = 1'b1; cyc(); grant_ack = 1'b0;
        req_c[3] = 1'b1; cyc(); req_c[3] = 1'b0;
        check("s7_busy", busy, 1);
        check("s7_pend", pend[2*NCH+3], 1);
        #2 rst_n = 1'b0;
        #1;
        check("s7_rst_vld", grant_vld, 0);
        check("s7_rst_busy", busy, 0);
        check("s7_rst_pend", pend, 0);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("s7_no_grant", grant_vld, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
